// File: rtl/cpu_writeback_arbiter.sv
// Write-back arbiter for the single register-file write port, with a
// per-register scoreboard of results still in flight.
module cpu_writeback_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*5-1:0]  i_req_rd,
  input  logic [NUM_REQ*32-1:0] i_req_value,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_wb_strobe,
  output logic [4:0]            o_wb_rd,
  output logic [31:0]           o_wb_value,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  output logic                  o_issue_ready,
  input  logic [4:0]            i_chk_rs1,
  input  logic [4:0]            i_chk_rs2,
  input  logic [4:0]            i_chk_rs3,
  output logic                  o_hazard
);

  localparam int RR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [RR_W-1:0] rr;
  logic [RR_W-1:0] grant_idx;
  logic [RR_W-1:0] rr_next;
  logic            grant_any;
  logic [4:0]      sel_rd;
  logic [31:0]     sel_value;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic            issue_fire;

  function automatic logic is_pending(input logic [31:0] pend, input logic [4:0] r);
    return (r != 5'd0) && pend[r];
  endfunction

  // Round-robin search starting at rr, wrapping at NUM_REQ.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    int idx;
    logic [RR_W-1:0] cand;
    o_req_ready = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = RR_W'(idx);
      if (!grant_any && i_req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) o_req_ready[grant_idx] = 1'b1;
  end

  assign sel_rd    = i_req_rd[int'(grant_idx)*5 +: 5];
  assign sel_value = i_req_value[int'(grant_idx)*32 +: 32];
  assign rr_next   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  assign o_issue_ready = !is_pending(pending, i_issue_rd);
  assign issue_fire    = i_issue_valid && o_issue_ready;
  assign o_hazard      = is_pending(pending, i_chk_rs1) ||
                         is_pending(pending, i_chk_rs2) ||
                         is_pending(pending, i_chk_rs3);

  // Clear is applied before set so a same-edge set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (grant_any && sel_rd != 5'd0)       pending_nxt[sel_rd]     = 1'b0;
    if (issue_fire && i_issue_rd != 5'd0)  pending_nxt[i_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr          <= '0;
      o_wb_strobe <= 1'b0;
      o_wb_rd     <= 5'd0;
      o_wb_value  <= 32'd0;
      pending     <= '0;
    end else begin
      if (grant_any) begin
        rr          <= rr_next;
        o_wb_strobe <= ~o_wb_strobe;
        o_wb_rd     <= sel_rd;
        o_wb_value  <= sel_value;
      end
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Self-checking bench for cpu_writeback_arbiter: directed scenarios plus a
// randomized run against a queue-free behavioural model of arbiter and scoreboard.
module tb_cpu_writeback_arbiter;

  localparam int N = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            wb_strobe;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_value;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      rs1, rs2, rs3;
  logic            hazard;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int        rr_m;
  bit [31:0] pend_m;
  bit        strobe_m;
  bit [4:0]  rd_m;
  bit [31:0] val_m;
  int        last_grant;

  cpu_writeback_arbiter #(.NUM_REQ(N)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .i_req_rd     (req_rd),
    .i_req_value  (req_value),
    .o_req_ready  (req_ready),
    .o_wb_strobe  (wb_strobe),
    .o_wb_rd      (wb_rd),
    .o_wb_value   (wb_value),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .o_issue_ready(issue_ready),
    .i_chk_rs1    (rs1),
    .i_chk_rs2    (rs2),
    .i_chk_rs3    (rs3),
    .o_hazard     (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (rr_m + off) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_pend(input logic [4:0] r);
    return (r != 0) && pend_m[r];
  endfunction

  task automatic model_reset();
    rr_m = 0; pend_m = '0; strobe_m = 0; rd_m = 0; val_m = 0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rd = '0; req_value = '0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  task automatic set_req(input int n, input logic [4:0] rd, input logic [31:0] v);
    req_valid[n] = 1'b1;
    req_rd[n*5 +: 5] = rd;
    req_value[n*32 +: 32] = v;
  endtask

  // One clock: check combinational outputs against the model, clock, advance
  // the model and check the registered write-back outputs.
  task automatic step(input string name);
    int g;
    logic [N-1:0] exp_ready;
    bit exp_iready, exp_haz, accept_issue;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_iready = !model_pend(issue_rd);
    exp_haz = model_pend(rs1) || model_pend(rs2) || model_pend(rs3);
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL %s ready: got %b expected %b", name, req_ready, exp_ready);
    end
    checks++;
    if (issue_ready !== exp_iready) begin
      failures++;
      $display("FAIL %s issue_ready: got %b expected %b", name, issue_ready, exp_iready);
    end
    checks++;
    if (hazard !== exp_haz) begin
      failures++;
      $display("FAIL %s hazard: got %b expected %b", name, hazard, exp_haz);
    end
    accept_issue = issue_valid && exp_iready && issue_rd != 0;
    @(posedge clk);
    last_grant = g;
    if (g >= 0) begin
      rd_m = req_rd[g*5 +: 5];
      val_m = req_value[g*32 +: 32];
      strobe_m = ~strobe_m;
      rr_m = (g + 1) % N;
      if (rd_m != 0) pend_m[rd_m] = 1'b0;
    end
    if (accept_issue) pend_m[issue_rd] = 1'b1;
    #1;
    checks++;
    if (wb_strobe !== strobe_m || wb_rd !== rd_m || wb_value !== val_m) begin
      failures++;
      $display("FAIL %s wb: got s=%b rd=%0d v=%h expected s=%b rd=%0d v=%h",
               name, wb_strobe, wb_rd, wb_value, strobe_m, rd_m, val_m);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if (wb_strobe !== 1'b0 || wb_rd !== 5'd0 || wb_value !== 32'd0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_state: got s=%b rd=%0d v=%h ready=%b expected all zero",
               wb_strobe, wb_rd, wb_value, req_ready);
    end
    checks++;
    if (issue_ready !== 1'b1 || hazard !== 1'b0) begin
      failures++;
      $display("FAIL reset_scoreboard: got issue_ready=%b hazard=%b expected 1/0", issue_ready, hazard);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    idle_inputs();
    set_req(1, 5'd7, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL single_ready: got %b expected 010", req_ready);
    end
    step("single");
    checks++;
    if (wb_strobe !== 1'b1 || wb_rd !== 5'd7 || wb_value !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_wb: got s=%b rd=%0d v=%h expected 1 7 deadbeef", wb_strobe, wb_rd, wb_value);
    end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd5;
    step("mid_issue5");
    issue_valid = 0;
    for (int i = 0; i < 2 && !strobe_m; i++) begin
      idle_inputs();
      set_req(0, 5'd20, 32'h1234_0000 + i);
      step("mid_wb");
    end
    idle_inputs();
    rs1 = 5'd5;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (wb_strobe !== 1'b0 || wb_rd !== 5'd0 || wb_value !== 32'd0 || hazard !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got s=%b rd=%0d v=%h hazard=%b expected 0 0 0 0",
               wb_strobe, wb_rd, wb_value, hazard);
    end
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL mid_reset_rr: got %b expected 001", req_ready);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    int toggles = 0;
    logic prev;
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < N; n++) set_req(n, 5'(n + 1), {16'hA000 + 16'(i / N), 16'(n)});
      #1;
      checks++;
      if (req_ready !== N'(1 << order[i])) begin
        failures++;
        $display("FAIL rr_grant%0d: got %b expected one-hot %0d", i, req_ready, order[i]);
      end
      prev = wb_strobe;
      step("rr");
      if (wb_strobe !== prev) toggles++;
      checks++;
      if (wb_value !== {16'hA000 + 16'(i / N), 16'(order[i])}) begin
        failures++;
        $display("FAIL rr_value%0d: got %h expected %h", i, wb_value, {16'hA000 + 16'(i / N), 16'(order[i])});
      end
    end
    checks++;
    if (toggles != 6) begin
      failures++;
      $display("FAIL rr_toggles: got %0d expected 6", toggles);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd10;
    step("sb_issue10");
    issue_valid = 0; rs2 = 5'd10;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL sb_hazard_set: got %b expected 1", hazard);
    end
    issue_valid = 1; issue_rd = 5'd10;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL sb_waw_stall: got %b expected 0", issue_ready);
    end
    step("sb_reissue");
    issue_valid = 0;
    set_req(2, 5'd10, 32'h0000_00AA);
    step("sb_wb10");
    idle_inputs();
    rs2 = 5'd10; issue_rd = 5'd10;
    #1;
    checks++;
    if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL sb_cleared: got hazard=%b issue_ready=%b expected 0/1", hazard, issue_ready);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    logic prev;
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd0;
    step("x0_issue");
    idle_inputs();
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL x0_hazard: got %b expected 0", hazard);
    end
    prev = wb_strobe;
    set_req(0, 5'd0, 32'h5555_5555);
    step("x0_wb");
    checks++;
    if (wb_strobe !== ~prev || wb_rd !== 5'd0) begin
      failures++;
      $display("FAIL x0_wb_toggle: got s=%b rd=%0d expected s=%b rd=0", wb_strobe, wb_rd, ~prev);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd4;
    step("sim_issue4");
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd3;
    set_req(1, 5'd4, 32'h0404_0404);
    step("sim_set3_clr4");
    idle_inputs();
    rs1 = 5'd3;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL sim_pend3: got %b expected 1", hazard);
    end
    rs1 = 5'd4;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL sim_pend4: got %b expected 0", hazard);
    end
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd9;
    set_req(0, 5'd9, 32'h0909_0909);
    step("sim_set_wins");
    idle_inputs();
    rs3 = 5'd9;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL sim_pend9: got %b expected 1", hazard);
    end
    // Drain the scoreboard so the random phase starts from a known state.
    idle_inputs();
    set_req(0, 5'd3, 32'h3); step("sim_drain3");
    set_req(0, 5'd9, 32'h9); step("sim_drain9");
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int n = 0; n < N; n++) begin
        req_rd[n*5 +: 5] = 5'($urandom_range(0, 7));
        req_value[n*32 +: 32] = $urandom;
      end
      issue_valid = 1'($urandom);
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rs3 = 5'($urandom_range(0, 31));
      step("random");
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midstream();
    test_round_robin();
    test_scoreboard();
    test_x0();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_writeback_arbiter.md
# cpu_writeback_arbiter

Shares the single register-file write port between several result producers (ALU, load unit, multiplier/divider, CSR) and tracks which destination registers have results still in flight. It drives the toggle-strobe write interface of `CPU_Registers` (`strobe`, `inst_rd`, `rd`), and tells the issue stage when a source or destination register is still pending.

## Interface

**Parameters**

- `NUM_REQ`, default 3: number of write-back requesters, range 2..4.

**Ports**

- `i_clock` in, 1: clock, rising edge.
- `i_reset_n` in, 1: asynchronous active-low reset.
- `i_req_valid` in, NUM_REQ: requester *n* has a result.
- `i_req_rd` in, NUM_REQ*5: destination register index, slice *n* = [5n+4:5n].
- `i_req_value` in, NUM_REQ*32: result value, slice *n* = [32n+31:32n].
- `o_req_ready` out, NUM_REQ: one-hot grant (or all zero); the transfer occurs on `valid & ready` at the clock edge.
- `o_wb_strobe` out, 1: toggles once per accepted write-back.
- `o_wb_rd` out, 5: register index of the last accepted write-back.
- `o_wb_value` out, 32: value of the last accepted write-back.
- `i_issue_valid` in, 1: the issue stage dispatches an instruction that writes `i_issue_rd`.
- `i_issue_rd` in, 5: destination register of the dispatched instruction.
- `o_issue_ready` out, 1: the dispatch may be accepted.
- `i_chk_rs1`, `i_chk_rs2`, `i_chk_rs3` in, 5 each: source registers of the instruction in issue.
- `o_hazard` out, 1: at least one nonzero source register is pending.

## Operation

**Arbitration**

- Round-robin pointer `rr`, range 0..NUM_REQ-1, reset value 0.
- The grant goes to the first requester with `valid` set, searching from index `rr` upward and wrapping at NUM_REQ.
- `o_req_ready` is combinational from `i_req_valid` and `rr`. It is one-hot on the granted requester and zero everywhere when no requester is valid.
- On an accepted transfer from requester *g*:
  - `o_wb_rd` is loaded with `req_rd[g]` and `o_wb_value` with `req_value[g]`.
  - `o_wb_strobe` is inverted.
  - `rr` becomes (g+1) mod NUM_REQ.
- With no transfer, the outputs and `rr` hold.
- At most one transfer per cycle, which matches the register file's single write port.
- A write-back with rd = 0 is still accepted and still toggles the strobe. The register file discards it.

**Scoreboard**

- `pending[31:1]` holds one bit per register; reset value is all 0. Register x0 is never pending.
- Set: on `i_issue_valid & o_issue_ready` with `i_issue_rd != 0`, the bit `pending[i_issue_rd]` is set.
- Clear: on an accepted write-back with rd != 0, the bit `pending[rd]` is cleared at the same edge.
- `o_issue_ready` is low when `i_issue_rd != 0` and `pending[i_issue_rd]` is set. This stalls write-after-write. Otherwise it is high.
- `o_hazard` is the OR over rs1/rs2/rs3 of (`rsX != 0` and `pending[rsX]`). It is combinational and reflects the pending bits as of the current cycle.

**Boundary and simultaneous-event rules**

- Same-edge set and clear of the same register: this can only happen if a write-back arrives for a register that is not pending, which is a protocol violation. Set wins and the bit ends the cycle set.
- Same-edge set of register A and clear of register B (A != B): both take effect.
- A write-back to a register that is not pending is accepted and does not change the scoreboard.
- Issue while `i_issue_valid` is low: no scoreboard change.
- `rr` wraps from NUM_REQ-1 to 0.
- Reset assertion mid-operation takes effect immediately and asynchronously:
  - `o_wb_strobe` = 0, `o_wb_rd` = 0, `o_wb_value` = 0.
  - `rr` = 0 and `pending` = 0.
  - In-flight results are lost.
  - Producers must also be reset. The register file's `last_write_strobe` resets to 0 as well, so the two stay consistent.

## Timing

- Write-back latency:
  - Edge E: the handshake; strobe, rd and value update.
  - Edge E+1: the register file commits the write.
  - A read of that register issued at E+1 or later returns the new value.
- Pending clear happens at edge E. `o_hazard` can therefore drop in cycle E+1, and a dependent instruction read at E+1 sees the committed value at E+2.
- `o_req_ready`, `o_issue_ready` and `o_hazard` are combinational. They have no dependency on themselves through combinational paths.
- Throughput: one write-back per cycle with zero-bubble back-to-back grants.
- Fairness: any continuously valid requester is granted within NUM_REQ cycles.

## Test plan

1. **Reset.** Assert `i_reset_n` = 0 mid-stream with strobe = 1 and `pending[5]` set → immediately strobe = 0, rd = 0, value = 0, `o_hazard` = 0 for rs1 = 5, and `rr` = 0.
2. **Single write-back.** Requester 1 presents rd = 7, value = 0xDEADBEEF → `o_req_ready` = 3'b010; after the edge, strobe toggles 0→1, `o_wb_rd` = 7, `o_wb_value` = 0xDEADBEEF.
3. **Round-robin.** All three requesters stay valid for 6 cycles → grant order 0,1,2,0,1,2; strobe toggles 6 times; each value appears exactly once per round.
4. **Scoreboard.**
   - Issue rd = 10 → `o_hazard` = 1 for rs2 = 10.
   - A second issue to rd = 10 → `o_issue_ready` = 0.
   - Write-back rd = 10 → the next cycle has `o_hazard` = 0 and `o_issue_ready` = 1.
5. **x0 handling.**
   - Issue rd = 0 → no pending bit set, `o_hazard` = 0 for rs1 = 0.
   - Write-back rd = 0 → strobe toggles, scoreboard unchanged.
6. **Simultaneous events.**
   - Same edge: issue rd = 3 and write-back rd = 4 (4 pending) → `pending[3]` = 1, `pending[4]` = 0.
   - Write-back to non-pending rd = 9 together with issue rd = 9 → `pending[9]` = 1.
